// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: shared definitions for the RV32I decode stage.
//   - RV32I major opcode constants (OPC_*)
//   - 4-bit ALU operation codes (ALU_*) consumed by execute
//   - id_ex_t: the registered ID/EX bundle handed to execute
//   - alu_from_funct3(): maps funct3/funct7[5] to an ALU code
package decode_stage_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        src_a_pc;
    logic        src_b_imm;
    logic [2:0]  funct3;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        illegal;
  } id_ex_t;

  // alt is ir[30]. For OP-IMM only the shift-right pair looks at it;
  // ADDI has no subtract form, so is_reg gates the SUB selection.
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3,
                                                 input logic       alt,
                                                 input logic       is_reg);
    logic [3:0] op;
    op = ALU_ADD;
    case (funct3)
      3'b000: op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = alt ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// regfile: 32 x XLEN integer register file, two async read ports, one
// synchronous write port, with same-cycle write-to-read bypass.
//   clk, reset        clock (rising), async active-low reset (clears x1..x31)
//   raddr1/raddr2     read indices; rdata1/rdata2 combinational read data
//   we/waddr/wdata    writeback port, written on the rising edge
// x0 is never written and always reads as zero.
module regfile
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs_q [0:NREG-1];
  logic [XLEN-1:0] regs_d [0:NREG-1];

  always_comb begin
    regs_d = regs_q;
    regs_d[0] = '0;
    for (int i = 1; i < NREG; i++) begin
      if (we && (waddr == i[4:0])) regs_d[i] = wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Bypass: a value being written this cycle is visible to the reader now,
  // so decode never sees a stale operand for an instruction in writeback.
  always_comb begin
    rdata1 = '0;
    if (raddr1 != 5'd0) rdata1 = (we && (waddr == raddr1)) ? wdata : regs_q[raddr1];
  end

  always_comb begin
    rdata2 = '0;
    if (raddr2 != 5'd0) rdata2 = (we && (waddr == raddr2)) ? wdata : regs_q[raddr2];
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: ID stage of the 5-stage RV32I pipeline.
//   clk, reset            clock (rising), async active-low reset
//   ir, npc               instruction in decode and its address
//   flush                 taken branch/jump resolved in EX; kills decode
//   wb_we/wb_rd/wb_data   writeback port into the register file
//   stallF, stallD        hold PC / hold ir+npc (load-use hazard)
//   ex_*                  registered ID/EX bundle for execute
//
// Stall contract: stallF/stallD are combinational from this cycle's ir and the
// current ID/EX contents. When high, fetch must hold ir/npc unchanged for the
// next cycle while this stage loads a bubble; flush overrides and forces both
// low. There is no other flow control between fetch and decode.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] ir,
  input  logic [XLEN-1:0] npc,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            stallF,
  output logic            stallD,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_imm,
  output logic [3:0]      ex_alu_op,
  output logic            ex_src_a_pc,
  output logic            ex_src_b_imm,
  output logic [2:0]      ex_funct3,
  output logic            ex_is_branch,
  output logic            ex_is_jal,
  output logic            ex_is_jalr,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write,
  output logic            ex_illegal
);

  id_ex_t ex_q, ex_d;
  logic   d_valid_q, d_valid_d;

  // Decode fields
  logic [6:0]  opcode;
  logic [4:0]  rd_f, rs1_f, rs2_f;
  logic [2:0]  funct3_f;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  // Control decode results
  logic        legal, use_rs1, use_rs2;
  logic [31:0] imm;
  logic [3:0]  alu_op;
  logic        src_a_pc, src_b_imm;
  logic        is_branch, is_jal, is_jalr;
  logic        mem_read, mem_write, reg_write;

  logic [4:0]  rs1_idx, rs2_idx;
  logic [31:0] rs1_val, rs2_val;
  logic        hazard, stall;

  always_comb begin
    opcode   = ir[6:0];
    rd_f     = ir[11:7];
    funct3_f = ir[14:12];
    rs1_f    = ir[19:15];
    rs2_f    = ir[24:20];
    imm_i    = {{20{ir[31]}}, ir[31:20]};
    imm_s    = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    imm_b    = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    imm_u    = {ir[31:12], 12'b0};
    imm_j    = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  end

  always_comb begin
    legal     = 1'b1;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    imm       = '0;
    alu_op    = ALU_ADD;
    src_a_pc  = 1'b0;
    src_b_imm = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    case (opcode)
      OPC_OP: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; reg_write = 1'b1;
        alu_op  = alu_from_funct3(funct3_f, ir[30], 1'b1);
      end
      OPC_OP_IMM: begin
        use_rs1 = 1'b1; reg_write = 1'b1; src_b_imm = 1'b1; imm = imm_i;
        alu_op  = alu_from_funct3(funct3_f, ir[30], 1'b0);
      end
      OPC_LOAD: begin
        use_rs1 = 1'b1; reg_write = 1'b1; mem_read = 1'b1;
        src_b_imm = 1'b1; imm = imm_i;
      end
      OPC_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; mem_write = 1'b1;
        src_b_imm = 1'b1; imm = imm_s;
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; is_branch = 1'b1;
        imm = imm_b; alu_op = ALU_SUB;
      end
      // Link value is pc+4: A takes the PC, EX supplies the constant.
      OPC_JAL: begin
        is_jal = 1'b1; reg_write = 1'b1; src_a_pc = 1'b1; imm = imm_j;
      end
      OPC_JALR: begin
        use_rs1 = 1'b1; is_jalr = 1'b1; reg_write = 1'b1; src_a_pc = 1'b1;
        imm = imm_i;
      end
      OPC_LUI: begin
        reg_write = 1'b1; src_b_imm = 1'b1; imm = imm_u; alu_op = ALU_PASSB;
      end
      OPC_AUIPC: begin
        reg_write = 1'b1; src_a_pc = 1'b1; src_b_imm = 1'b1; imm = imm_u;
      end
      default: legal = 1'b0;
    endcase
  end

  // Unused source fields read as x0, which also keeps them out of the
  // hazard compare below (ex_rd==0 never matches).
  assign rs1_idx = use_rs1 ? rs1_f : 5'd0;
  assign rs2_idx = use_rs2 ? rs2_f : 5'd0;

  regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .raddr1 (rs1_idx),
    .raddr2 (rs2_idx),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val),
    .we     (wb_we),
    .waddr  (wb_rd),
    .wdata  (wb_data)
  );

  always_comb begin
    hazard = d_valid_q && ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) &&
             (((rs1_idx == ex_q.rd)) || ((rs2_idx == ex_q.rd)));
    stall  = hazard && !flush;
  end

  assign stallF = stall;
  assign stallD = stall;

  always_comb begin
    d_valid_d = 1'b1;
    ex_d      = '0;
    if (d_valid_q && !flush && !hazard) begin
      if (legal) begin
        ex_d.valid     = 1'b1;
        ex_d.pc        = npc;
        ex_d.rs1       = rs1_idx;
        ex_d.rs2       = rs2_idx;
        ex_d.rs1_val   = rs1_val;
        ex_d.rs2_val   = rs2_val;
        ex_d.rd        = reg_write ? rd_f : 5'd0;
        ex_d.imm       = imm;
        ex_d.alu_op    = alu_op;
        ex_d.src_a_pc  = src_a_pc;
        ex_d.src_b_imm = src_b_imm;
        ex_d.funct3    = funct3_f;
        ex_d.is_branch = is_branch;
        ex_d.is_jal    = is_jal;
        ex_d.is_jalr   = is_jalr;
        ex_d.mem_read  = mem_read;
        ex_d.mem_write = mem_write;
        ex_d.reg_write = reg_write;
      end else begin
        ex_d.illegal = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q      <= '0;
      d_valid_q <= 1'b0;
    end else begin
      ex_q      <= ex_d;
      d_valid_q <= d_valid_d;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_pc        = ex_q.pc;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign ex_rs1_val   = ex_q.rs1_val;
  assign ex_rs2_val   = ex_q.rs2_val;
  assign ex_rd        = ex_q.rd;
  assign ex_imm       = ex_q.imm;
  assign ex_alu_op    = ex_q.alu_op;
  assign ex_src_a_pc  = ex_q.src_a_pc;
  assign ex_src_b_imm = ex_q.src_b_imm;
  assign ex_funct3    = ex_q.funct3;
  assign ex_is_branch = ex_q.is_branch;
  assign ex_is_jal    = ex_q.is_jal;
  assign ex_is_jalr   = ex_q.is_jalr;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_illegal   = ex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: self-checking bench for decode_stage.
module tb_decode_stage;
  import decode_stage_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        src_a_pc;
    logic        src_b_imm;
    logic [2:0]  funct3;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        illegal;
  } out_t;

  localparam int OW = $bits(out_t);

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exp_stall;
    out_t        want;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [31:0] ir, npc, wb_data;
  logic        flush, wb_we;
  logic [4:0]  wb_rd;
  logic        stallF, stallD;
  logic        ex_valid, ex_src_a_pc, ex_src_b_imm;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_alu_op;
  logic [2:0]  ex_funct3;
  logic        ex_is_branch, ex_is_jal, ex_is_jalr;
  logic        ex_mem_read, ex_mem_write, ex_reg_write, ex_illegal;

  decode_stage dut (
    .clk(clk), .reset(reset), .ir(ir), .npc(npc), .flush(flush),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .stallF(stallF), .stallD(stallD),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_rd(ex_rd),
    .ex_imm(ex_imm), .ex_alu_op(ex_alu_op), .ex_src_a_pc(ex_src_a_pc),
    .ex_src_b_imm(ex_src_b_imm), .ex_funct3(ex_funct3),
    .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal)
  );

  // scoreboard
  logic [OW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs [15];

  function automatic out_t sample();
    out_t o;
    o.valid = ex_valid;         o.pc = ex_pc;
    o.rs1 = ex_rs1;             o.rs2 = ex_rs2;
    o.rs1_val = ex_rs1_val;     o.rs2_val = ex_rs2_val;
    o.rd = ex_rd;               o.imm = ex_imm;
    o.alu_op = ex_alu_op;       o.src_a_pc = ex_src_a_pc;
    o.src_b_imm = ex_src_b_imm; o.funct3 = ex_funct3;
    o.is_branch = ex_is_branch; o.is_jal = ex_is_jal;
    o.is_jalr = ex_is_jalr;     o.mem_read = ex_mem_read;
    o.mem_write = ex_mem_write; o.reg_write = ex_reg_write;
    o.illegal = ex_illegal;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [OW-1:0] got, input logic [OW-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, got, want);
    end
  endtask

  task automatic chk_stall(input string nm, input logic want);
    n_cmp++;
    if ({stallF, stallD} !== {want, want}) begin
      n_bad++;
      $display("FAIL %s stall: got stallF=%b stallD=%b required %b", nm, stallF, stallD, want);
    end
  endtask

  // driver: called just after a rising edge; drives one decode cycle,
  // checks the combinational stall mid-cycle, then the ID/EX result.
  task automatic apply(input vec_t v, input string nm);
    logic [OW-1:0] want;
    ir = v.ir; npc = v.npc; flush = v.flush;
    wb_we = v.wb_we; wb_rd = v.wb_rd; wb_data = v.wb_data;
    exp_q.push_back(v.want);
    @(negedge clk);
    chk_stall(nm, v.exp_stall);
    @(posedge clk); #1;
    wb_we = 1'b0; flush = 1'b0;
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: scoreboard empty, got %h", nm, sample());
    end else begin
      want = exp_q.pop_front();
      chk(nm, sample(), want);
    end
  endtask

  localparam logic [31:0] I_LW  = 32'h0000A283; // lw x5,0(x1)
  localparam logic [31:0] I_ADD = 32'h00528333; // add x6,x5,x5

  vec_t v_lw, v_add_stall, v_add;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{ir:32'h00500093, npc:32'h8000, wb_we:1'b1, wb_rd:5'd1, wb_data:32'd5,
                 want:'{valid:1'b1, pc:32'h8000, rd:5'd1, imm:32'd5, alu_op:ALU_ADD,
                        src_b_imm:1'b1, reg_write:1'b1, default:'0}, default:'0};
    vecs[1]  = '{ir:32'h00018233, npc:32'h8004, wb_we:1'b1, wb_rd:5'd3, wb_data:32'hDEADBEEF,
                 want:'{valid:1'b1, pc:32'h8004, rs1:5'd3, rs1_val:32'hDEADBEEF, rd:5'd4,
                        alu_op:ALU_ADD, reg_write:1'b1, default:'0}, default:'0};
    vecs[2]  = '{ir:32'h40118433, npc:32'h8008,
                 want:'{valid:1'b1, pc:32'h8008, rs1:5'd3, rs2:5'd1, rs1_val:32'hDEADBEEF,
                        rs2_val:32'd5, rd:5'd8, alu_op:ALU_SUB, reg_write:1'b1, default:'0}, default:'0};
    vecs[3]  = '{ir:32'h0030A423, npc:32'h800C,
                 want:'{valid:1'b1, pc:32'h800C, rs1:5'd1, rs2:5'd3, rs1_val:32'd5,
                        rs2_val:32'hDEADBEEF, imm:32'd8, alu_op:ALU_ADD, src_b_imm:1'b1,
                        funct3:3'd2, mem_write:1'b1, default:'0}, default:'0};
    vecs[4]  = '{ir:32'hFE002E23, npc:32'h8010,
                 want:'{valid:1'b1, pc:32'h8010, imm:32'hFFFFFFFC, alu_op:ALU_ADD,
                        src_b_imm:1'b1, funct3:3'd2, mem_write:1'b1, default:'0}, default:'0};
    vecs[5]  = '{ir:32'h123454B7, npc:32'h8014,
                 want:'{valid:1'b1, pc:32'h8014, rd:5'd9, imm:32'h12345000, alu_op:ALU_PASSB,
                        src_b_imm:1'b1, funct3:3'd5, reg_write:1'b1, default:'0}, default:'0};
    vecs[6]  = '{ir:32'hFFFFF517, npc:32'h8018,
                 want:'{valid:1'b1, pc:32'h8018, rd:5'd10, imm:32'hFFFFF000, alu_op:ALU_ADD,
                        src_a_pc:1'b1, src_b_imm:1'b1, funct3:3'd7, reg_write:1'b1, default:'0}, default:'0};
    vecs[7]  = '{ir:32'hFF9FF0EF, npc:32'h801C,
                 want:'{valid:1'b1, pc:32'h801C, rd:5'd1, imm:32'hFFFFFFF8, alu_op:ALU_ADD,
                        src_a_pc:1'b1, funct3:3'd7, is_jal:1'b1, reg_write:1'b1, default:'0}, default:'0};
    vecs[8]  = '{ir:32'h00008067, npc:32'h8020,
                 want:'{valid:1'b1, pc:32'h8020, rs1:5'd1, rs1_val:32'd5, alu_op:ALU_ADD,
                        src_a_pc:1'b1, is_jalr:1'b1, reg_write:1'b1, default:'0}, default:'0};
    vecs[9]  = '{ir:32'hFE000EE3, npc:32'h8024,
                 want:'{valid:1'b1, pc:32'h8024, imm:32'hFFFFFFFC, alu_op:ALU_SUB,
                        is_branch:1'b1, default:'0}, default:'0};
    vecs[10] = '{ir:32'h00309863, npc:32'h8028,
                 want:'{valid:1'b1, pc:32'h8028, rs1:5'd1, rs2:5'd3, rs1_val:32'd5,
                        rs2_val:32'hDEADBEEF, imm:32'd16, alu_op:ALU_SUB, funct3:3'd1,
                        is_branch:1'b1, default:'0}, default:'0};
    vecs[11] = '{ir:32'hFFFFFFFF, npc:32'h802C,
                 want:'{illegal:1'b1, default:'0}, default:'0};
    vecs[12] = '{ir:32'h4041D593, npc:32'h8030,
                 want:'{valid:1'b1, pc:32'h8030, rs1:5'd3, rs1_val:32'hDEADBEEF, rd:5'd11,
                        imm:32'h00000404, alu_op:ALU_SRA, src_b_imm:1'b1, funct3:3'd5,
                        reg_write:1'b1, default:'0}, default:'0};
    vecs[13] = '{ir:32'h000003B3, npc:32'h8034, wb_we:1'b1, wb_rd:5'd0, wb_data:32'h1234,
                 want:'{valid:1'b1, pc:32'h8034, rd:5'd7, alu_op:ALU_ADD, reg_write:1'b1,
                        default:'0}, default:'0};
    vecs[14] = '{ir:32'h000003B3, npc:32'h8038,
                 want:'{valid:1'b1, pc:32'h8038, rd:5'd7, alu_op:ALU_ADD, reg_write:1'b1,
                        default:'0}, default:'0};

    v_lw = '{ir:I_LW, npc:32'h9000,
             want:'{valid:1'b1, pc:32'h9000, rs1:5'd1, rs1_val:32'd5, rd:5'd5, alu_op:ALU_ADD,
                    src_b_imm:1'b1, funct3:3'd2, mem_read:1'b1, reg_write:1'b1, default:'0}, default:'0};
    v_add_stall = '{ir:I_ADD, npc:32'h9004, exp_stall:1'b1, want:'{default:'0}, default:'0};
    v_add = '{ir:I_ADD, npc:32'h9004, wb_we:1'b1, wb_rd:5'd5, wb_data:32'hCAFE0001,
              want:'{valid:1'b1, pc:32'h9004, rs1:5'd5, rs2:5'd5, rs1_val:32'hCAFE0001,
                     rs2_val:32'hCAFE0001, rd:5'd6, alu_op:ALU_ADD, reg_write:1'b1,
                     default:'0}, default:'0};

    // reset: hold a real instruction on ir the whole time
    reset = 1'b0; ir = 32'h00500093; npc = 32'h8000; flush = 1'b0;
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", sample(), '0);
    chk_stall("reset", 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("first_ir_bubble", sample(), '0);

    // table-driven decode vectors
    for (int i = 0; i < 15; i++) apply(vecs[i], $sformatf("vec[%0d]", i));

    // load-use: one stall cycle, bubble, then the add issues
    apply(v_lw, "lu_load");
    apply(v_add_stall, "lu_stall");
    apply(v_add, "lu_issue");

    // flush of a branch, then flush coinciding with a load-use hazard
    apply('{ir:32'hFE000EE3, npc:32'h9010, flush:1'b1, want:'{default:'0}, default:'0}, "flush_branch");
    apply(v_lw, "fh_load");
    apply('{ir:I_ADD, npc:32'h9004, flush:1'b1, want:'{default:'0}, default:'0}, "flush_hazard");
    v_add.wb_we = 1'b0;
    apply(v_add, "after_flush");

    // reset asserted while a stall is active
    apply(v_lw, "rs_load");
    ir = I_ADD; npc = 32'h9004;
    @(negedge clk);
    chk_stall("rs_pre", 1'b1);
    #1 reset = 1'b0;
    #1;
    chk_stall("rs_async", 1'b0);
    chk("rs_async_ex", sample(), '0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rs_first_bubble", sample(), '0);
    // registers were cleared by reset, so the operands read back zero
    apply('{ir:I_ADD, npc:32'h9004,
            want:'{valid:1'b1, pc:32'h9004, rs1:5'd5, rs2:5'd5, rd:5'd6, alu_op:ALU_ADD,
                   reg_write:1'b1, default:'0}, default:'0}, "rs_issue");

    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
